// File: rtl/mac16_pkg.sv
// Shared definitions for the 16-bit MAC datapath: widths, FSM states and the
// saturation limits used by the accumulation controller.
package mac16_pkg;

   localparam int ACC_W  = 32;
   localparam int PROD_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } acc_state_t;

   localparam logic [ACC_W-1:0] SAT_POS = 32'h7FFF_FFFF;
   localparam logic [ACC_W-1:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/Kogge_stone_32bit.sv
// 32-bit Kogge-Stone parallel-prefix adder: sum = a + b + cin, with carry out.
// Five prefix levels (spans 1, 2, 4, 8, 16) over generate/propagate pairs.
module Kogge_stone_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [31:0]      p0;
   logic [5:0][31:0] gg;
   logic [4:0][31:0] pp;

   // Bit-level generate/propagate; cin is folded into bit 0's generate so the
   // prefix tree yields carries directly.
   assign p0       = a ^ b;
   assign pp[0]    = p0;
   assign gg[0][0] = (a[0] & b[0]) | (p0[0] & cin);
   assign gg[0][31:1] = a[31:1] & b[31:1];

   genvar l, i;
   for (l = 0; l < 5; l++) begin : g_lvl
      for (i = 0; i < 32; i++) begin : g_bit
         if (i >= (1 << l)) begin : g_comb
            assign gg[l+1][i] = gg[l][i] | (pp[l][i] & gg[l][i-(1<<l)]);
            if (l < 4) begin : g_p
               assign pp[l+1][i] = pp[l][i] & pp[l][i-(1<<l)];
            end
         end else begin : g_pass
            assign gg[l+1][i] = gg[l][i];
            if (l < 4) begin : g_p
               assign pp[l+1][i] = pp[l][i];
            end
         end
      end
   end

   // Carry into bit i is the group generate of bits [i-1:0].
   assign sum  = p0 ^ {gg[5][30:0], cin};
   assign cout = gg[5][31];

endmodule

// File: rtl/mac16_acc_ctrl.sv
// Accumulation controller: sums a programmed number of 32-bit products from
// the multiplier and presents the final sum on a valid/ready port.
// Optional feature macro: MAC_ACC_SAT_EN (saturate on signed overflow;
// default build wraps modulo 2^32 and only flags overflow).
module mac16_acc_ctrl
   import mac16_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              clr,
   input  logic              prod_valid,
   input  logic [PROD_W-1:0] prod,
   output logic              prod_ready,
   output logic              acc_valid,
   output logic [ACC_W-1:0]  acc_data,
   input  logic              acc_ready,
   output logic              busy,
   output logic              ovf
);

   acc_state_t       state, state_nxt;
   logic [ACC_W-1:0] acc, sum, acc_nxt;
   logic [LEN_W-1:0] cnt, len_q;
   logic             ovf_q;
   logic             beat, last_beat, beat_ovf;

   assign beat      = (state == ACCUM) && prod_valid;
   assign last_beat = beat && (cnt == len_q - LEN_W'(1));

   Kogge_stone_32bit u_add (
      .a    (acc),
      .b    (prod),
      .cin  (1'b0),
      .sum  (sum),
      .cout ()
   );

   // Signed overflow: operands agree in sign, result disagrees.
   assign beat_ovf = (acc[ACC_W-1] == prod[PROD_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef MAC_ACC_SAT_EN
   // Clamp toward the sign of the operands on overflow.
   assign acc_nxt = beat_ovf ? (acc[ACC_W-1] ? SAT_NEG : SAT_POS) : sum;
`else
   assign acc_nxt = sum;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; clr overrides everything, including start.
   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
            ACCUM:   if (last_beat) state_nxt = DONE;
            DONE:    if (acc_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Handshake/status outputs decoded from registered state only.
   always_comb begin
      prod_ready = (state == ACCUM);
      acc_valid  = (state == DONE);
      busy       = (state != IDLE);
   end

   // Accumulator, beat counter, latched length and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         cnt   <= '0;
         len_q <= '0;
         ovf_q <= 1'b0;
      end else if (clr) begin
         acc   <= '0;
         cnt   <= '0;
         ovf_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               acc   <= '0;
               cnt   <= '0;
               ovf_q <= 1'b0;
               len_q <= len;
            end
            ACCUM: if (beat) begin
               acc <= acc_nxt;
               cnt <= cnt + LEN_W'(1);
               if (beat_ovf) ovf_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign acc_data = acc;
   assign ovf      = ovf_q;

endmodule
